multdiv: RTL

//  Iterative signed 32-bit multiply/divide unit that sits beside the ALU inside processor.
//  The pipeline issues a one-cycle ctrl_MULT/ctrl_DIV pulse with operands.

---
 rtl/multdiv_pkg.sv | 34 +++
 rtl/multdiv_booth_step.sv | 23 ++
 rtl/multdiv.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states, adder op select,
// the most-negative operand constant and the Booth pair decoder.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;
    localparam logic [MD_WIDTH-1:0] MIN_INT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        BOP_PASS = 2'd0,
        BOP_ADD  = 2'd1,
        BOP_SUB  = 2'd2
    } booth_op_e;

    // Radix-2 Booth: {q0, q-1} = 01 adds the multiplicand, 10 subtracts it.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        op = BOP_PASS;
        case (pair)
            2'b01:   op = BOP_ADD;
            2'b10:   op = BOP_SUB;
            default: op = BOP_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multdiv_booth_step.sv
// Combinational add/sub/pass on a WIDTH+1-bit accumulator; Booth step for MUL,
// trial subtract for DIV. The extra bit keeps every sum exact.
module multdiv_booth_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH:0] acc_i,
    input  logic [WIDTH:0] addend_i,
    input  booth_op_e      op_i,
    output logic [WIDTH:0] sum_o
);

    always_comb begin
        sum_o = acc_i;
        case (op_i)
            BOP_ADD: sum_o = acc_i + addend_i;
            BOP_SUB: sum_o = acc_i - addend_i;
            default: sum_o = acc_i;
        endcase
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (Booth) / divide (restoring) unit with one-cycle RDY pulse.
// Define MULTDIV_EARLY_DIV0_EN to report divide-by-zero straight from the accept edge.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int PW = 2*WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] min_val;
    generate
        if (WIDTH == MD_WIDTH) begin : g_min_pkg
            assign min_val = MIN_INT;
        end else begin : g_min_gen
            assign min_val = {1'b1, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // product_q layout: MUL {upper, multiplier, q-1}; DIV {remainder, dividend/quotient, 0}.
    logic [WIDTH:0] step_acc, step_addend, step_sum;
    booth_op_e      step_op;
    logic [PW-1:0]  step_next;

    always_comb begin
        step_acc    = product_q[PW-1 -: WIDTH+1];
        step_addend = {1'b0, mcand_q};
        step_op     = BOP_SUB;
        if (state_q == ST_MUL) begin
            step_acc    = {product_q[PW-1], product_q[PW-1 -: WIDTH]};
            step_addend = {mcand_q[WIDTH-1], mcand_q};
            step_op     = booth_decode(product_q[1:0]);
        end
    end

    multdiv_booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (step_acc),
        .addend_i (step_addend),
        .op_i     (step_op),
        .sum_o    (step_sum)
    );

    // MUL keeps the exact WIDTH+1-bit sum, which is the arithmetic shift right by one.
    always_comb begin
        if (state_q == ST_MUL) begin
            step_next = {step_sum, product_q[WIDTH:1]};
        end else begin
            step_next = {(step_sum[WIDTH] ? step_acc[WIDTH-1:0] : step_sum[WIDTH-1:0]),
                         product_q[WIDTH-1:1], ~step_sum[WIDTH], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH-1:0]   quot_mag;
    logic               mul_ovf;
    assign prod_full = product_q[PW-1:1];
    assign quot_mag  = product_q[WIDTH:1];
    assign mul_ovf   = ~((&prod_full[2*WIDTH-1:WIDTH-1]) | ~(|prod_full[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;
        result_d  = result_q;
        exc_d     = exc_q;

        case (state_q)
            ST_MUL, ST_DIV: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    if (state_q == ST_MUL) begin
                        result_d = prod_full[WIDTH-1:0];
                        exc_d    = mul_ovf;
                    end else if (div0_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quot_mag : quot_mag;
                        exc_d    = ovf_q;
                    end
                end else begin
                    product_d = step_next;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new pulse restarts from any state; the aborted op never reaches DONE.
        if (ctrl_MULT | ctrl_DIV) begin
            cnt_d = '0;
            exc_d = 1'b0;
            if (ctrl_MULT) begin
                state_d   = ST_MUL;
                product_d = {{WIDTH{1'b0}}, data_operandB, 1'b0};
                mcand_d   = data_operandA;
            end else begin
                state_d   = ST_DIV;
                product_d = {{WIDTH{1'b0}}, abs_a, 1'b0};
                mcand_d   = abs_b;
                div0_d    = (data_operandB == '0);
                ovf_d     = (data_operandA == min_val) && (data_operandB == '1);
                neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef MULTDIV_EARLY_DIV0_EN
                if (data_operandB == '0) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            product_q <= '0;
            mcand_q   <= '0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);

endmodule
